// File: rtl/blob_binarizer_pkg.sv
// Shared definitions for the blob pipeline front end.
// Holds the default frame geometry, the binarizer FSM state type, the pixel/luma
// width used by the blob stages and the luma helper.
package blob_binarizer_pkg;

    localparam int unsigned IMG_COL_DEF  = 800;
    localparam int unsigned IMG_ROW_DEF  = 600;
    localparam int unsigned TAIL_LEN_DEF = 200;

    // Camera colour channels and luma share one width.
    localparam int unsigned LUMA_W     = 12;
    localparam int unsigned LUMA_SUM_W = LUMA_W + 2;
    // Wide enough for a full 800x600 frame of ones.
    localparam int unsigned ONES_W     = 19;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StStream,
        StTail,
        StProc
    } bin_state_e;

    // Y = (R + 2G + B) / 4. The 14-bit sum cannot overflow, so no saturation.
    function automatic logic [LUMA_W-1:0] luma_of(input logic [LUMA_W-1:0] r,
                                                  input logic [LUMA_W-1:0] g,
                                                  input logic [LUMA_W-1:0] b);
        logic [LUMA_SUM_W-1:0] sum;
        sum = LUMA_SUM_W'(r) + LUMA_SUM_W'({g, 1'b0}) + LUMA_SUM_W'(b);
        return sum[LUMA_SUM_W-1:2];
    endfunction

endpackage

// File: rtl/blob_luma_thresh.sv
// Two-stage pixel datapath: stage 1 registers the luma, stage 2 registers the
// thresholded (and optionally inverted) binary bit. Pure datapath; the caller
// decides which cycles carry a pixel via valid_i.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   valid_i              pixel qualifier entering stage 1
//   r_i, g_i, b_i        colour channels
//   thresh_i, invert_i   threshold and output polarity (held stable per frame)
//   valid_s1_o           stage-1 valid (pixel one cycle from the output)
//   valid_o, seq_o       stage-2 valid and binary pixel (seq_o is 0 when invalid)
module blob_luma_thresh
    import blob_binarizer_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [LUMA_W-1:0] r_i,
    input  logic [LUMA_W-1:0] g_i,
    input  logic [LUMA_W-1:0] b_i,
    input  logic [LUMA_W-1:0] thresh_i,
    input  logic              invert_i,
    output logic              valid_s1_o,
    output logic              valid_o,
    output logic              seq_o
);

    logic              valid_s1_q, valid_s1_d;
    logic [LUMA_W-1:0] luma_q, luma_d;
    logic              valid_s2_q, valid_s2_d;
    logic              seq_q, seq_d;

    always_comb begin
        valid_s1_d = valid_i;
        luma_d     = luma_of(r_i, g_i, b_i);
        valid_s2_d = valid_s1_q;
        // Gate with valid so the binary output is never 1 between pixels.
        seq_d      = valid_s1_q & ((luma_q >= thresh_i) ^ invert_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_s1_q <= 1'b0;
            luma_q     <= '0;
            valid_s2_q <= 1'b0;
            seq_q      <= 1'b0;
        end else begin
            valid_s1_q <= valid_s1_d;
            luma_q     <= luma_d;
            valid_s2_q <= valid_s2_d;
            seq_q      <= seq_d;
        end
    end

    assign valid_s1_o = valid_s1_q;
    assign valid_o    = valid_s2_q;
    assign seq_o      = seq_q;

endmodule

// File: rtl/blob_binarizer.sv
// Captures one camera frame on request, binarizes it by luma threshold and
// streams it to the blob labelling stage, then waits for labelling to finish.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start                 request one frame (honoured only when idle)
//   i_sof, i_pix_valid      camera frame strobe and pixel qualifier
//   i_r, i_g, i_b           camera RGB
//   i_thresh, i_invert      luma threshold and output polarity, latched on start
//   i_blob_done             labelling finished
//   o_valid, o_data_valid   frame-active and pixel qualifier to the blob stage
//   o_seq, o_proc_ccd       binary pixel and processing window to the blob stage
//   o_busy                  not idle
//   o_ones                  count of 1 pixels in the current/last frame
//   o_frame_done            pulse while labelling completes
module blob_binarizer
    import blob_binarizer_pkg::*;
#(
    parameter int unsigned IMG_COL  = IMG_COL_DEF,
    parameter int unsigned IMG_ROW  = IMG_ROW_DEF,
    parameter int unsigned TAIL_LEN = TAIL_LEN_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_sof,
    input  logic              i_pix_valid,
    input  logic [LUMA_W-1:0] i_r,
    input  logic [LUMA_W-1:0] i_g,
    input  logic [LUMA_W-1:0] i_b,
    input  logic [LUMA_W-1:0] i_thresh,
    input  logic              i_invert,
    input  logic              i_blob_done,
    output logic              o_valid,
    output logic              o_data_valid,
    output logic              o_seq,
    output logic              o_proc_ccd,
    output logic              o_busy,
    output logic [ONES_W-1:0] o_ones,
    output logic              o_frame_done
);

    localparam int unsigned COL_W  = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
    localparam int unsigned ROW_W  = (IMG_ROW > 1) ? $clog2(IMG_ROW) : 1;
    localparam int unsigned TAIL_W = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_COL - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_ROW - 1);
    localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_LEN - 1);

    bin_state_e        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [TAIL_W-1:0] tail_q, tail_d;
    logic [LUMA_W-1:0] thresh_q, thresh_d;
    logic              invert_q, invert_d;
    logic              valid_q, valid_d;
    logic [ONES_W-1:0] ones_q, ones_d;

    logic pix_accept;
    logic pipe_s1_valid;
    logic pipe_valid;
    logic pipe_seq;

    assign pix_accept = (state_q == StStream) && i_pix_valid;

    blob_luma_thresh u_luma_thresh (
        .clk_i      (i_clk),
        .rst_ni     (i_rst_n),
        .valid_i    (pix_accept),
        .r_i        (i_r),
        .g_i        (i_g),
        .b_i        (i_b),
        .thresh_i   (thresh_q),
        .invert_i   (invert_q),
        .valid_s1_o (pipe_s1_valid),
        .valid_o    (pipe_valid),
        .seq_o      (pipe_seq)
    );

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        tail_d   = tail_q;
        thresh_d = thresh_q;
        invert_d = invert_q;
        valid_d  = valid_q;
        ones_d   = ones_q;

        if (pipe_valid && pipe_seq) begin
            ones_d = ones_q + ONES_W'(1);
        end
        // Raise o_valid together with the first pixel leaving stage 2.
        if (pipe_s1_valid) begin
            valid_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d  = StArm;
                    thresh_d = i_thresh;
                    invert_d = i_invert;
                    ones_d   = '0;
                    col_d    = '0;
                    row_d    = '0;
                end
            end
            StArm: begin
                if (i_sof) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (i_pix_valid) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            tail_d  = '0;
                            state_d = StTail;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            StTail: begin
                // Tail cycles are counted only once the pipeline has drained,
                // i.e. from the cycle after the last o_data_valid.
                if (!pipe_s1_valid && !pipe_valid) begin
                    if (tail_q == TAIL_LAST) begin
                        state_d = StProc;
                        valid_d = 1'b0;
                    end else begin
                        tail_d = tail_q + TAIL_W'(1);
                    end
                end
            end
            StProc: begin
                if (i_blob_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            col_q    <= '0;
            row_q    <= '0;
            tail_q   <= '0;
            thresh_q <= '0;
            invert_q <= 1'b0;
            valid_q  <= 1'b0;
            ones_q   <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            tail_q   <= tail_d;
            thresh_q <= thresh_d;
            invert_q <= invert_d;
            valid_q  <= valid_d;
            ones_q   <= ones_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_data_valid = pipe_valid;
    assign o_seq        = pipe_seq;
    assign o_busy       = (state_q != StIdle);
    assign o_proc_ccd   = (state_q != StIdle);
    assign o_ones       = ones_q;
    assign o_frame_done = (state_q == StProc) && i_blob_done;

endmodule

// File: tb/tb_blob_binarizer.sv
// Scoreboard bench for blob_binarizer on a reduced 8x6 frame with a 20-cycle tail.
// Stimulus pushes the expected (cycle, bit) of every accepted pixel; a negedge
// monitor pops and compares whenever o_data_valid is seen.
module tb_blob_binarizer;

    localparam int unsigned COLS = 8;
    localparam int unsigned ROWS = 6;
    localparam int unsigned TAIL = 20;
    localparam int unsigned NPIX = COLS * ROWS;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start, i_sof, i_pix_valid, i_invert, i_blob_done;
    logic [11:0] i_r, i_g, i_b, i_thresh;
    logic        o_valid, o_data_valid, o_seq, o_proc_ccd, o_busy, o_frame_done;
    logic [18:0] o_ones;

    blob_binarizer #(
        .IMG_COL  (COLS),
        .IMG_ROW  (ROWS),
        .TAIL_LEN (TAIL)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_sof        (i_sof),
        .i_pix_valid  (i_pix_valid),
        .i_r          (i_r),
        .i_g          (i_g),
        .i_b          (i_b),
        .i_thresh     (i_thresh),
        .i_invert     (i_invert),
        .i_blob_done  (i_blob_done),
        .o_valid      (o_valid),
        .o_data_valid (o_data_valid),
        .o_seq        (o_seq),
        .o_proc_ccd   (o_proc_ccd),
        .o_busy       (o_busy),
        .o_ones       (o_ones),
        .o_frame_done (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    int unsigned cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Pixel table with hand-computed luma (R + 2G + B) >> 2.
    logic [11:0] tab_r [5] = '{12'h100, 12'hFFF, 12'h000, 12'h1FF, 12'h1FF};
    logic [11:0] tab_g [5] = '{12'h200, 12'hFFF, 12'h000, 12'h200, 12'h200};
    logic [11:0] tab_b [5] = '{12'h300, 12'hFFF, 12'h000, 12'h201, 12'h200};
    logic [11:0] tab_y [5] = '{12'h200, 12'hFFF, 12'h000, 12'h200, 12'h1FF};

    typedef struct packed {
        logic [31:0] cyc;
        logic        seq;
    } exp_t;

    exp_t        sb [$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned last_dv = 0;

    // Bench-side model of what the DUT should be doing.
    logic [11:0] cur_th;
    logic        cur_inv;
    bit          m_arm, m_stream;
    int unsigned m_acc;
    int unsigned ones_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst_n === 1'b1) begin
            if (o_data_valid === 1'b1) begin
                last_dv = cyc;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_dv: o_data_valid at cycle %0d, none expected", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("dv_cycle", cyc, e.cyc);
                    chk("o_seq", {31'b0, o_seq}, {31'b0, e.seq});
                    chk("o_valid_with_dv", {31'b0, o_valid}, 32'd1);
                end
            end else if (o_seq !== 1'b0) begin
                n_vec++;
                n_err++;
                $display("FAIL seq_without_dv: o_seq=%b at cycle %0d, expected 0", o_seq, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic exp_bit(input int idx);
        return (tab_y[idx] >= cur_th) ^ cur_inv;
    endfunction

    // One clock of camera/control stimulus.
    task automatic cycle_px(input bit pv, input int idx, input bit sof, input bit bd,
                            input bit st);
        exp_t e;
        i_pix_valid = pv;
        i_r         = tab_r[idx];
        i_g         = tab_g[idx];
        i_b         = tab_b[idx];
        i_sof       = sof;
        i_blob_done = bd;
        i_start     = st;
        if (m_stream && pv && m_acc < NPIX) begin
            e.cyc = cyc + 2;
            e.seq = exp_bit(idx);
            sb.push_back(e);
            m_acc++;
            ones_exp += {31'b0, e.seq};
        end
        if (m_arm && sof) begin
            m_arm    = 1'b0;
            m_stream = 1'b1;
        end
        if (bd) begin
            #1;
            chk("frame_done_ignored", {31'b0, o_frame_done}, 32'd0);
        end
        tick();
        i_pix_valid = 1'b0;
        i_sof       = 1'b0;
        i_blob_done = 1'b0;
        i_start     = 1'b0;
    endtask

    task automatic start_frame(input logic [11:0] th, input logic inv);
        i_start  = 1'b1;
        i_thresh = th;
        i_invert = inv;
        cur_th   = th;
        cur_inv  = inv;
        m_arm    = 1'b1;
        m_stream = 1'b0;
        m_acc    = 0;
        ones_exp = 0;
        tick();
        i_start  = 1'b0;
        // Scramble the live inputs: only the latched values may matter.
        i_thresh = ~th;
        i_invert = ~inv;
        chk("arm_busy", {31'b0, o_busy}, 32'd1);
        chk("arm_proc_ccd", {31'b0, o_proc_ccd}, 32'd1);
        chk("arm_valid_low", {31'b0, o_valid}, 32'd0);
        chk("arm_ones_clear", {13'b0, o_ones}, 32'd0);
    endtask

    task automatic finish_frame();
        int n = 0;
        while (o_valid === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) begin
            n_vec++;
            n_err++;
            $display("FAIL tail_timeout: o_valid still %b after %0d cycles", o_valid, n);
        end
        chk("o_valid_fall_cycle", cyc, last_dv + TAIL + 1);
        chk("proc_busy", {31'b0, o_busy}, 32'd1);
        chk("proc_ccd", {31'b0, o_proc_ccd}, 32'd1);
        chk("frame_ones", {13'b0, o_ones}, ones_exp);
        chk("sb_drained", sb.size(), 32'd0);
        i_blob_done = 1'b1;
        #1;
        chk("frame_done_pulse", {31'b0, o_frame_done}, 32'd1);
        tick();
        i_blob_done = 1'b0;
        #1;
        chk("frame_done_single", {31'b0, o_frame_done}, 32'd0);
        chk("idle_busy", {31'b0, o_busy}, 32'd0);
        chk("idle_proc_ccd", {31'b0, o_proc_ccd}, 32'd0);
        chk("idle_ones_held", {13'b0, o_ones}, ones_exp);
        m_stream = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_valid"}, {31'b0, o_valid}, 32'd0);
        chk({nm, "_data_valid"}, {31'b0, o_data_valid}, 32'd0);
        chk({nm, "_seq"}, {31'b0, o_seq}, 32'd0);
        chk({nm, "_proc_ccd"}, {31'b0, o_proc_ccd}, 32'd0);
        chk({nm, "_busy"}, {31'b0, o_busy}, 32'd0);
        chk({nm, "_ones"}, {13'b0, o_ones}, 32'd0);
        chk({nm, "_frame_done"}, {31'b0, o_frame_done}, 32'd0);
    endtask

    initial begin
        repeat (20000) @(posedge i_clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;  i_sof = 1'b0;  i_pix_valid = 1'b0;  i_blob_done = 1'b0;
        i_r = '0;  i_g = '0;  i_b = '0;  i_thresh = '0;  i_invert = 1'b0;
        m_arm = 1'b0;  m_stream = 1'b0;  m_acc = 0;  ones_exp = 0;
        cur_th = '0;  cur_inv = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        i_rst_n = 1'b1;
        tick();

        // Frame A: thresh 0x200, 1-in-3 duty, pre-sof pixels, stray sof/start/blob_done.
        start_frame(12'h200, 1'b0);
        for (int p = 0; p < 3; p++) cycle_px(1'b1, p, 1'b0, 1'b0, 1'b0);
        cycle_px(1'b1, 0, 1'b1, 1'b0, 1'b0);
        for (int p = 0; p < int'(NPIX); p++) begin
            cycle_px(1'b1, p % 5, p == 20, p == 30, 1'b0);
            cycle_px(1'b0, 0, 1'b0, 1'b0, p == 25);
            cycle_px(1'b0, 0, 1'b0, 1'b0, 1'b0);
        end
        for (int p = 0; p < 3; p++) cycle_px(1'b1, 1, 1'b0, 1'b0, 1'b0);
        finish_frame();

        // Frame B: thresh 0x201 inverted, dense stream.
        start_frame(12'h201, 1'b1);
        cycle_px(1'b0, 0, 1'b1, 1'b0, 1'b0);
        for (int p = 0; p < int'(NPIX); p++) cycle_px(1'b1, p % 5, 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 3; p++) cycle_px(1'b1, 1, 1'b0, 1'b0, 1'b0);
        finish_frame();

        // Frame C: all-white, reset at row 3, then a clean frame.
        start_frame(12'h800, 1'b0);
        cycle_px(1'b0, 0, 1'b1, 1'b0, 1'b0);
        for (int p = 0; p < int'(COLS * 3); p++) cycle_px(1'b1, 1, 1'b0, 1'b0, 1'b0);
        i_rst_n = 1'b0;
        #2;
        chk_all_zero("midframe_reset");
        sb.delete();
        m_arm = 1'b0;  m_stream = 1'b0;  m_acc = 0;  ones_exp = 0;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        cycle_px(1'b1, 1, 1'b1, 1'b0, 1'b0);
        chk("sof_without_start", {31'b0, o_busy}, 32'd0);
        start_frame(12'h800, 1'b0);
        cycle_px(1'b0, 0, 1'b1, 1'b0, 1'b0);
        for (int p = 0; p < int'(NPIX); p++) cycle_px(1'b1, 1, 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 3; p++) cycle_px(1'b1, 1, 1'b0, 1'b0, 1'b0);
        finish_frame();
        chk("white_frame_ones", {13'b0, o_ones}, NPIX);

        repeat (3) tick();
        chk("final_sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/blob_binarizer.md
BLOB_BINARIZER -- requirements
Module: blob_binarizer

Interface
REQ-001 Parameter IMG_COL, default 800, pixels per row.
REQ-002 Parameter IMG_ROW, default 600, rows per frame.
REQ-003 Parameter TAIL_LEN, default 200, cycles o_valid stays high after last pixel.
REQ-004 Port i_clk  input  1  single clock for all logic.
REQ-005 Port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 Port i_start  input  1  one-cycle request to capture one frame.
REQ-007 Port i_sof  input  1  start-of-frame strobe from camera.
REQ-008 Port i_pix_valid  input  1  camera pixel qualifier.
REQ-009 Port i_r, i_g, i_b  input  12 each  camera RGB.
REQ-010 Port i_thresh  input  12  luma threshold.
REQ-011 Port i_invert  input  1  invert binary output.
REQ-012 Port i_blob_done  input  1  blob stage o_valid (labelling finished).
REQ-013 Port o_valid  output  1  frame-active to blob stage i_valid.
REQ-014 Port o_data_valid  output  1  pixel qualifier to blob stage i_data_valid.
REQ-015 Port o_seq  output  1  binary pixel to blob stage i_seq.
REQ-016 Port o_proc_ccd  output  1  processing window to blob stage i_proc_ccd.
REQ-017 Port o_busy  output  1  high in any state except IDLE.
REQ-018 Port o_ones  output  19  count of o_seq=1 pixels in current/last frame.
REQ-019 Port o_frame_done  output  1  one-cycle pulse on PROC->IDLE.

Function
REQ-020 FSM states IDLE, ARM, STREAM, TAIL, PROC; one state register.
REQ-021 IDLE->ARM on i_start; i_start in any other state ignored.
REQ-022 On IDLE->ARM: latch i_thresh and i_invert; clear o_ones and row/col counters.
REQ-023 ARM->STREAM on i_sof; pixels in ARM ignored, including pixels in the i_sof cycle.
REQ-024 In STREAM, each i_pix_valid cycle is accepted and increments col; col wraps IMG_COL-1->0 and increments row.
REQ-025 i_sof during STREAM, TAIL, PROC ignored; i_pix_valid outside STREAM ignored.
REQ-026 Luma Y = (R + 2G + B) >> 2, 14-bit intermediate sum, 12-bit result, no saturation needed.
REQ-027 Binary bit = (Y >= latched threshold) XOR latched invert.
REQ-028 Pixel path is 2 register stages: pixel accepted at cycle N appears with o_data_valid=1 at cycle N+2; gaps in i_pix_valid preserved.
REQ-029 Exactly IMG_ROW*IMG_COL pixels accepted per frame; STREAM->TAIL in the cycle after accepting pixel (IMG_ROW-1, IMG_COL-1).
REQ-030 o_valid rises with first o_data_valid; stays high through TAIL_LEN cycles after last o_data_valid; then TAIL->PROC.
REQ-031 o_proc_ccd high from ARM entry through PROC; low in IDLE.
REQ-032 PROC->IDLE on i_blob_done; o_frame_done pulses that cycle; i_blob_done in other states ignored.
REQ-033 o_ones increments with each o_data_valid carrying o_seq=1; holds value in IDLE until next ARM.
REQ-034 o_seq is 0 whenever o_data_valid is 0.

Reset
REQ-035 Asynchronous assertion of i_rst_n=0 forces IDLE, counters 0, pipeline valids 0, latched threshold 0, invert 0.
REQ-036 All outputs 0 in reset, including o_ones.
REQ-037 Reset mid-frame abandons the frame; no o_frame_done pulse; next frame requires new i_start.

Structure
REQ-038 Shared package holds IMG_ROW/IMG_COL defaults, the FSM state enum, and the luma width constant (12) used by blob stages.
REQ-039 One sub-module, blob_luma_thresh: registered luma + compare, 2-stage latency, no control logic.

Verification
REQ-040 i_start, i_sof, 480000 pixels of R=G=B=0xFFF, thresh 0x800 -> 480000 o_data_valid with o_seq=1, o_ones=480000, o_valid low 200 cycles after last.
REQ-041 Single pixel R=0x100,G=0x200,B=0x300 (Y=0x200), thresh 0x200 -> o_seq=1 two cycles later; thresh 0x201 -> o_seq=0; invert=1 flips both.
REQ-042 Pixels sent in ARM before i_sof plus extra i_sof mid-STREAM -> pre-sof pixels dropped, count still 480000, no restart.
REQ-043 i_pix_valid with 1-in-3 duty -> o_data_valid identical pattern delayed 2 cycles; row wrap at col 799 verified.
REQ-044 i_rst_n low at row 300 -> all outputs 0 immediately; then i_start/i_sof full frame completes normally.
REQ-045 i_blob_done pulsed in STREAM (ignored), then in PROC -> o_frame_done single pulse, o_proc_ccd falls, o_busy 0.
